netbus_rx5: RTL and testbench
=============================

Name: netbus_rx5

Overview:
- Five-to-one packet-aware merge; the receive-side counterpart of the NetBus five-way broadcast transmitter.
- Collects streams from five NetBus sources, arbitrates round-robin at packet granularity and presents one registered NetBus stream downstream.
- Sits at a node's ingress, ahead of packet-processing logic; grant is held from first beat to the beat carrying the LAST flag.

Parameters:
- DATA_WIDTH, 4, NetBus lane parameter; beat width W = DATA_WIDTH*9+14.
- LAST_BIT, DATA_WIDTH*9+13, bit index within a beat marking end of packet.
- IDLE_TIMEOUT, 256, stall cycles before forced lock release (only with optional feature; range 2..65535).

Ports:
- CLK  in  1  single clock for all inputs/outputs.
- RST  in  1  asynchronous, active-high reset.
- RDATA0..RDATA4  in  W  beat from source n.
- RVALID0..RVALID4  in  1  beat valid from source n.
- RREADY0..RREADY4  out  1  beat accepted from source n.
- DATA  out  W  merged beat (registered).
- VALID  out  1  merged beat valid (registered).
- READY  in  1  downstream accept.

Behaviour:
- Reset (async assert, sync release): VALID=0, DATA=0, all RREADYn=0, state IDLE, rr pointer=0, grant index=0. Any partial packet in flight is abandoned; no resume after reset.
- Handshake: a beat transfers on a cycle where valid&&ready are both 1. VALID/DATA change only when the output register loads or drains. A beat is never dropped or duplicated.
- FSM IDLE:
  - All RREADYn=0.
  - If any RVALIDn=1, select the first requester scanning from pointer upward, mod 5. Register it as grant g and go to LOCKED next cycle (1-cycle arbitration bubble).
  - If no requester, stay in IDLE.
- FSM LOCKED:
  - RREADYg = (!VALID || READY); every other RREADYn=0.
  - On RVALIDg && RREADYg: DATA<=RDATAg, VALID<=1.
  - If that beat has bit LAST_BIT=1: go to IDLE and set pointer<=(g+1) mod 5.
- Output register: if VALID && READY and no load on that cycle, VALID<=0. Simultaneous drain and load keeps VALID=1 with new data, giving full throughput within a packet.
- Latency: input beat to DATA/VALID is 1 cycle. First beat of a packet is 2 cycles after RVALID rises from IDLE.
- Single-beat packet (LAST on first beat): lock released right after that beat; another source may be granted with the same 1-cycle bubble.
- A source dropping RVALIDg mid-packet keeps the lock; the arbiter waits indefinitely unless the optional feature is enabled.
- Non-granted sources must hold their RVALID/RDATA; they only see RREADYn=0.
- READY low for any duration stalls the granted source via RREADYg; the output register holds its beat.
- Fairness: with all five requesting continuously, grants rotate 0,1,2,3,4,0.

Optional Feature:
- Macro: NETBUS_RX5_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in LOCKED and counts cycles with RVALIDg=0; it clears on any RVALIDg=1 and on entry to LOCKED.
  - At IDLE_TIMEOUT: force IDLE, pointer<=(g+1) mod 5, counter cleared. No beat is injected, and the already-registered output beat still drains normally.
- Undefined: counter absent; lock is held until LAST.

Decomposition:
- Package netbus_pkg holds:
  - width function netbus_w(DATA_WIDTH);
  - state enum {IDLE, LOCKED};
  - port-count constant NETBUS_PORTS=5;
  - default LAST_BIT expression.
- Sub-module netbus_rr_arb5: combinational 5-way round-robin picker.
  - Inputs: req[4:0], ptr[2:0].
  - Outputs: gnt_idx[2:0], any.

Test Plan:
- Reset mid-packet: source 2 streams a 4-beat packet; RST asserted after beat 2 -> VALID=0 immediately, RREADY*=0, pointer=0. After release, source 0 wins first.
- Single source, READY=1: source 1 sends 3 beats, LAST on the 3rd -> DATA matches at cycles t+2, t+3, t+4 with no gaps; then returns to IDLE.
- All five request at once with 2-beat packets, READY=1 -> packet order 0,1,2,3,4 with a 1-cycle bubble between packets; no interleaving of beats.
- Backpressure: READY toggles 1,0,0,1 during a 4-beat packet -> RREADYg low during stalls, all 4 beats delivered exactly once and in order.
- Mid-packet RVALID gap: source 3 idles 10 cycles between beat 1 and beat 2 while source 4 requests -> source 4 stays ungranted until source 3's LAST beat.
- With NETBUS_RX5_TIMEOUT_EN and IDLE_TIMEOUT=8: source 3 stalls 8 cycles mid-packet while source 4 requests -> lock released and source 4 granted next cycle. With the macro off, source 3 stays granted.

Source files
------------

// File: rtl/netbus_pkg.sv
// Shared NetBus types and helpers for the five-to-one receive merge.
// Beat width, end-of-packet bit position and arbiter state encoding live here.
package netbus_pkg;

  localparam int NETBUS_PORTS = 5;

  typedef enum logic {IDLE, LOCKED} netbus_state_e;

  function automatic int netbus_w(input int dw);
    return dw * 9 + 14;
  endfunction

  function automatic int netbus_last_bit(input int dw);
    return dw * 9 + 13;
  endfunction

  function automatic logic [2:0] netbus_next(input logic [2:0] g);
    return (g >= 3'd4) ? 3'd0 : g + 3'd1;
  endfunction

endpackage

// File: rtl/netbus_rr_arb5.sv
// Combinational five-way round-robin picker: first requester at or above ptr, wrapping mod 5.
module netbus_rr_arb5
  import netbus_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic [2:0] gnt_idx,
  output logic       any
);

  // Scan from the farthest offset down so the nearest requester is the last to win.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = NETBUS_PORTS - 1; i >= 0; i--) begin
      int k;
      k = (int'(ptr) + i) % NETBUS_PORTS;
      if (req[k]) begin
        gnt_idx = 3'(k);
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/netbus_rx5.sv
// Five-to-one packet-aware NetBus merge with registered output and packet-granular round-robin.
// Optional stall timeout that releases a stuck lock: define NETBUS_RX5_TIMEOUT_EN.
module netbus_rx5
  import netbus_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int LAST_BIT   = netbus_last_bit(DATA_WIDTH)
`ifdef NETBUS_RX5_TIMEOUT_EN
  , parameter int IDLE_TIMEOUT = 256
`endif
  , localparam int W = netbus_w(DATA_WIDTH)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] RDATA0,
  input  logic [W-1:0] RDATA1,
  input  logic [W-1:0] RDATA2,
  input  logic [W-1:0] RDATA3,
  input  logic [W-1:0] RDATA4,
  input  logic         RVALID0,
  input  logic         RVALID1,
  input  logic         RVALID2,
  input  logic         RVALID3,
  input  logic         RVALID4,
  output logic         RREADY0,
  output logic         RREADY1,
  output logic         RREADY2,
  output logic         RREADY3,
  output logic         RREADY4,
  output logic [W-1:0] DATA,
  output logic         VALID,
  input  logic         READY
);

  logic [W-1:0]  rdata_a [NETBUS_PORTS];
  logic [4:0]    rvalid_v;
  logic [4:0]    rready_v;
  netbus_state_e state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [W-1:0]  data_q;
  logic          valid_q;
  logic          load;
  logic [W-1:0]  rdata_g;
  logic          rvalid_g;
  logic [2:0]    arb_idx;
  logic          arb_any;
`ifdef NETBUS_RX5_TIMEOUT_EN
  logic [15:0]   cnt_q, cnt_d;
`endif

  assign rdata_a[0] = RDATA0;
  assign rdata_a[1] = RDATA1;
  assign rdata_a[2] = RDATA2;
  assign rdata_a[3] = RDATA3;
  assign rdata_a[4] = RDATA4;
  assign rvalid_v   = {RVALID4, RVALID3, RVALID2, RVALID1, RVALID0};

  assign {RREADY4, RREADY3, RREADY2, RREADY1, RREADY0} = rready_v;

  assign rdata_g  = rdata_a[gnt_q];
  assign rvalid_g = rvalid_v[gnt_q];

  netbus_rr_arb5 u_arb (
    .req     (rvalid_v),
    .ptr     (ptr_q),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    rready_v = '0;
    load     = 1'b0;
`ifdef NETBUS_RX5_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef NETBUS_RX5_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (arb_any) begin
          gnt_d   = arb_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        // Accept only when the output register is empty or draining this cycle.
        rready_v[gnt_q] = !valid_q || READY;
        load            = rvalid_g && rready_v[gnt_q];
        if (load && rdata_g[LAST_BIT]) begin
          state_d = IDLE;
          ptr_d   = netbus_next(gnt_q);
        end
`ifdef NETBUS_RX5_TIMEOUT_EN
        if (rvalid_g) begin
          cnt_d = '0;
        end else if (cnt_q + 16'd1 == 16'(IDLE_TIMEOUT)) begin
          cnt_d   = '0;
          state_d = IDLE;
          ptr_d   = netbus_next(gnt_q);
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
`ifdef NETBUS_RX5_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
`ifdef NETBUS_RX5_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Output register: a load overrides a drain so back-to-back beats stream at full rate.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      data_q  <= rdata_g;
      valid_q <= 1'b1;
    end else if (valid_q && READY) begin
      valid_q <= 1'b0;
    end
  end

  assign DATA  = data_q;
  assign VALID = valid_q;

endmodule

// File: tb/tb_netbus_rx5.sv
// Directed bench for netbus_rx5: reset, streaming, fairness, backpressure and mid-packet gaps.
module tb_netbus_rx5;

  localparam int W = 50;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         READY = 1'b1;
  logic [4:0]   rv = '0;
  logic [W-1:0] rd [5];
  logic [4:0]   rr;
  logic [W-1:0] DATA;
  logic         VALID;

  logic [W-1:0] beats [5][8];
  int           len [5];
  int           idx [5];
  bit           en [5];
  logic [W-1:0] out_data [64];
  int           out_cyc [64];
  int           out_n = 0;
  int           cyc = 0;
  int           errs = 0;
  int           checks = 0;

  always #5 CLK = ~CLK;

  netbus_rx5 #(
    .DATA_WIDTH(4)
`ifdef NETBUS_RX5_TIMEOUT_EN
    , .IDLE_TIMEOUT(8)
`endif
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .RDATA0  (rd[0]),
    .RDATA1  (rd[1]),
    .RDATA2  (rd[2]),
    .RDATA3  (rd[3]),
    .RDATA4  (rd[4]),
    .RVALID0 (rv[0]),
    .RVALID1 (rv[1]),
    .RVALID2 (rv[2]),
    .RVALID3 (rv[3]),
    .RVALID4 (rv[4]),
    .RREADY0 (rr[0]),
    .RREADY1 (rr[1]),
    .RREADY2 (rr[2]),
    .RREADY3 (rr[3]),
    .RREADY4 (rr[4]),
    .DATA    (DATA),
    .VALID   (VALID),
    .READY   (READY)
  );

  function automatic logic [W-1:0] mk(input int s, input int i, input bit last);
    logic [W-2:0] p;
    p = (W-1)'(s * 16 + i);
    return {last, p};
  endfunction

  task automatic drive();
    for (int n = 0; n < 5; n++) begin
      if (en[n] && idx[n] < len[n]) begin
        rv[n] = 1'b1;
        rd[n] = beats[n][idx[n]];
      end else begin
        rv[n] = 1'b0;
        rd[n] = '0;
      end
    end
  endtask

  task automatic clear_src();
    for (int n = 0; n < 5; n++) begin
      en[n]  = 1'b0;
      idx[n] = 0;
      len[n] = 0;
    end
    out_n = 0;
    drive();
  endtask

  // One clock: record handshakes at the falling edge, advance sources after the rising edge.
  task automatic tick();
    logic [4:0] hs;
    @(negedge CLK);
    hs = rv & rr;
    if (VALID === 1'b1 && READY && out_n < 64) begin
      out_data[out_n] = DATA;
      out_cyc[out_n]  = cyc;
      out_n++;
    end
    @(posedge CLK);
    #1;
    cyc++;
    for (int n = 0; n < 5; n++)
      if (hs[n]) idx[n]++;
    drive();
  endtask

  task automatic test_reset();
    clear_src();
    RST = 1'b1;
    repeat (2) tick();
    checks++; if (VALID !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", VALID); end
    checks++; if (DATA !== '0) begin errs++; $display("FAIL reset_data got=%h exp=0", DATA); end
    checks++; if (rr !== 5'b0) begin errs++; $display("FAIL reset_rready got=%b exp=00000", rr); end
    RST = 1'b0;
    for (int i = 0; i < 4; i++) beats[2][i] = mk(2, i, i == 3);
    len[2] = 4; en[2] = 1'b1;
    drive();
    repeat (3) tick();
    checks++; if (DATA !== mk(2, 1, 0) || VALID !== 1'b1) begin
      errs++; $display("FAIL midpkt_beat got=%h/%b exp=%h/1", DATA, VALID, mk(2, 1, 0));
    end
    RST = 1'b1;
    #1;
    checks++; if (VALID !== 1'b0) begin errs++; $display("FAIL async_rst_valid got=%b exp=0", VALID); end
    checks++; if (DATA !== '0) begin errs++; $display("FAIL async_rst_data got=%h exp=0", DATA); end
    checks++; if (rr !== 5'b0) begin errs++; $display("FAIL async_rst_rready got=%b exp=00000", rr); end
    clear_src();
    beats[0][0] = mk(0, 0, 1); len[0] = 1; en[0] = 1'b1;
    beats[2][0] = mk(2, 7, 1); len[2] = 1; en[2] = 1'b1;
    drive();
    tick();
    RST = 1'b0;
    out_n = 0;
    repeat (7) tick();
    checks++; if (out_n !== 2) begin errs++; $display("FAIL post_rst_count got=%0d exp=2", out_n); end
    checks++; if (out_data[0] !== mk(0, 0, 1)) begin errs++; $display("FAIL post_rst_first got=%h exp=%h", out_data[0], mk(0, 0, 1)); end
    checks++; if (out_data[1] !== mk(2, 7, 1)) begin errs++; $display("FAIL post_rst_second got=%h exp=%h", out_data[1], mk(2, 7, 1)); end
  endtask

  task automatic test_single();
    int t;
    clear_src();
    for (int i = 0; i < 3; i++) beats[1][i] = mk(1, i, i == 2);
    len[1] = 3; en[1] = 1'b1;
    drive();
    t = cyc;
    repeat (8) tick();
    checks++; if (out_n !== 3) begin errs++; $display("FAIL single_count got=%0d exp=3", out_n); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_data[i] !== mk(1, i, i == 2)) begin
        errs++; $display("FAIL single_data%0d got=%h exp=%h", i, out_data[i], mk(1, i, i == 2));
      end
      checks++; if (out_cyc[i] !== t + 2 + i) begin
        errs++; $display("FAIL single_cycle%0d got=%0d exp=%0d", i, out_cyc[i] - t, 2 + i);
      end
    end
    checks++; if (rr !== 5'b0 || VALID !== 1'b0) begin
      errs++; $display("FAIL single_idle got=rr%b/v%b exp=rr00000/v0", rr, VALID);
    end
  endtask

  task automatic test_back_to_back();
    int t;
    clear_src();
    RST = 1'b1;
    #1;
    RST = 1'b0;
    for (int s = 0; s < 5; s++) begin
      beats[s][0] = mk(s, 0, 0);
      beats[s][1] = mk(s, 1, 1);
      len[s] = 2; en[s] = 1'b1;
    end
    drive();
    t = cyc;
    repeat (18) tick();
    checks++; if (out_n !== 10) begin errs++; $display("FAIL rr_count got=%0d exp=10", out_n); end
    for (int s = 0; s < 5; s++) begin
      for (int i = 0; i < 2; i++) begin
        checks++; if (out_data[2*s+i] !== mk(s, i, i == 1)) begin
          errs++; $display("FAIL rr_data%0d got=%h exp=%h", 2*s+i, out_data[2*s+i], mk(s, i, i == 1));
        end
        checks++; if (out_cyc[2*s+i] !== t + 2 + 3*s + i) begin
          errs++; $display("FAIL rr_cycle%0d got=%0d exp=%0d", 2*s+i, out_cyc[2*s+i] - t, 2 + 3*s + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int t;
    bit pat [10] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    int exp_c [4] = '{2, 5, 6, 7};
    clear_src();
    for (int i = 0; i < 4; i++) beats[0][i] = mk(0, i, i == 3);
    len[0] = 4; en[0] = 1'b1;
    t = cyc;
    for (int k = 0; k < 10; k++) begin
      READY = pat[k];
      drive();
      #1;
      if (k == 3 || k == 4) begin
        checks++; if (rr[0] !== 1'b0) begin errs++; $display("FAIL bp_stall_rready%0d got=%b exp=0", k, rr[0]); end
      end
      if (k == 4) begin
        checks++; if (DATA !== mk(0, 1, 0) || VALID !== 1'b1) begin
          errs++; $display("FAIL bp_hold got=%h/%b exp=%h/1", DATA, VALID, mk(0, 1, 0));
        end
      end
      if (k == 5) begin
        checks++; if (rr[0] !== 1'b1) begin errs++; $display("FAIL bp_resume_rready got=%b exp=1", rr[0]); end
      end
      tick();
    end
    READY = 1'b1;
    checks++; if (out_n !== 4) begin errs++; $display("FAIL bp_count got=%0d exp=4", out_n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_data[i] !== mk(0, i, i == 3) || out_cyc[i] !== t + exp_c[i]) begin
        errs++; $display("FAIL bp_beat%0d got=%h@%0d exp=%h@%0d", i, out_data[i], out_cyc[i] - t, mk(0, i, i == 3), exp_c[i]);
      end
    end
  endtask

  task automatic test_gap();
    int t;
    logic [W-1:0] exp_d [3];
    int           exp_c [3];
    bit           exp_rr3;
`ifdef NETBUS_RX5_TIMEOUT_EN
    exp_d = '{mk(3, 0, 0), mk(4, 0, 1), mk(3, 1, 1)};
    exp_c = '{2, 12, 14};
    exp_rr3 = 1'b0;
`else
    exp_d = '{mk(3, 0, 0), mk(3, 1, 1), mk(4, 0, 1)};
    exp_c = '{2, 13, 15};
    exp_rr3 = 1'b1;
`endif
    clear_src();
    beats[3][0] = mk(3, 0, 0); beats[3][1] = mk(3, 1, 1); len[3] = 2; en[3] = 1'b1;
    beats[4][0] = mk(4, 0, 1); len[4] = 1; en[4] = 1'b1;
    t = cyc;
    for (int k = 0; k < 18; k++) begin
      if (k == 2)  en[3] = 1'b0;
      if (k == 12) en[3] = 1'b1;
      drive();
      #1;
      if (k >= 2 && k <= 9) begin
        checks++; if (rr[4] !== 1'b0) begin errs++; $display("FAIL gap_src4_blocked%0d got=%b exp=0", k, rr[4]); end
      end
      if (k == 12) begin
        checks++; if (rr[3] !== exp_rr3) begin errs++; $display("FAIL gap_src3_lock got=%b exp=%b", rr[3], exp_rr3); end
      end
      tick();
    end
    checks++; if (out_n !== 3) begin errs++; $display("FAIL gap_count got=%0d exp=3", out_n); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_data[i] !== exp_d[i] || out_cyc[i] !== t + exp_c[i]) begin
        errs++; $display("FAIL gap_beat%0d got=%h@%0d exp=%h@%0d", i, out_data[i], out_cyc[i] - t, exp_d[i], exp_c[i]);
      end
    end
  endtask

  initial begin
    for (int n = 0; n < 5; n++) rd[n] = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_gap();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
